// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, RX FIFO defaults and the capture FSM state type.
package uart_pkg;

  localparam int unsigned UART_BYTE_W    = 8;
  localparam int unsigned RX_FIFO_DEPTH  = 16;
  localparam int unsigned RX_FIFO_ADDR_W = 4;
  localparam int unsigned RX_FIFO_THRESH = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StClr  = 2'd1,
    StWait = 2'd2
  } cap_state_e;

endpackage

// File: rtl/fifo_sync_fwft.sv
// Generic synchronous first-word-fall-through FIFO with fill counter and drop indication.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fifo_sync_fwft #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  output logic              push_drop,
  input  logic              pop,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   count_next
);

  localparam logic [ADDR_W:0] FullLvl = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              valid_q;
  logic              pop_ok, push_ok;

  always_comb begin
    pop_ok     = pop && valid_q;
    push_ok    = push && ((count_q != FullLvl) || pop_ok);
    push_drop  = push && !push_ok;
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_next;
      valid_q <= (count_next != '0);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign rd_data  = mem[rd_ptr_q];
  assign rd_valid = valid_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive-side byte capture into a FWFT FIFO with sticky overflow flag.
// Optional threshold interrupt enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
  parameter int unsigned ADDR_W = RX_FIFO_ADDR_W,
  parameter int unsigned THRESH = RX_FIFO_THRESH
) (
  input  logic                   clk_50m,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [UART_BYTE_W-1:0] rx_data,
  output logic                   rx_rdy_clr,
  output logic                   rd_valid,
  output logic [UART_BYTE_W-1:0] rd_data,
  input  logic                   rd_ready,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   irq
);

  cap_state_e      state_q, state_d;
  logic            clr_q, clr_d;
  logic            push;
  logic            push_drop;
  logic            ovf_q, ovf_d;
  logic [ADDR_W:0] count_next;

  // One push per rdy assertion; WAIT holds off until the receiver has dropped rdy.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_rdy) begin
          push    = 1'b1;
          clr_d   = 1'b1;
          state_d = StClr;
        end
      end
      StClr:   state_d = StWait;
      StWait:  if (!rx_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      state_q <= StIdle;
      clr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ovf_q   <= ovf_d;
    end
  end

  fifo_sync_fwft #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_BYTE_W)
  ) u_fifo (
    .clk        (clk_50m),
    .rst        (rst),
    .push       (push),
    .push_data  (rx_data),
    .push_drop  (push_drop),
    .pop        (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .count      (count),
    .count_next (count_next)
  );

  assign rx_rdy_clr = clr_q;
  assign overflow   = ovf_q;

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [ADDR_W:0] ThreshLvl = (ADDR_W + 1)'(THRESH);

  logic irq_q;

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count_next >= ThreshLvl);
    end
  end

  assign irq = irq_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^count_next ^ (THRESH != 0);
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic against a
// queue-based model where a byte is captured on every sampled rising level of rx_rdy.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned THRESH = 8;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy_clr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       irq;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (4),
    .THRESH (THRESH)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .irq        (irq)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, overflow flag, expected clear pulse.
  logic [7:0] mq[$];
  bit m_ovf = 1'b0, m_clr = 1'b0, prev_rdy = 1'b0, model_on = 1'b0;
  bit cap, popq, dropped, exp_irq;

  always @(posedge clk_50m) begin
    if (!rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_clr    = 1'b0;
      prev_rdy = 1'b0;
      model_on = 1'b1;
    end else begin
      cap      = rx_rdy && !prev_rdy;
      prev_rdy = rx_rdy;
      popq     = rd_ready && (mq.size() != 0);
      dropped  = 1'b0;
      if (popq) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_clr = cap;
    end
    if (model_on) begin
      #1;
`ifdef UART_RX_FIFO_THRESH_EN
      exp_irq = (mq.size() >= THRESH);
`else
      exp_irq = 1'b0;
`endif
      chk("count", count, mq.size());
      chk("rd_valid", rd_valid, mq.size() != 0);
      if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
      chk("overflow", overflow, m_ovf);
      chk("rx_rdy_clr", rx_rdy_clr, m_clr);
      chk("irq", irq, exp_irq);
    end
  end

  task automatic tick();
    @(negedge clk_50m);
  endtask

  // Behaves like the receiver: holds rdy until it has seen rdy_clr, drops it one edge later.
  task automatic send_byte(input logic [7:0] b, output int lat);
    rx_data = b;
    rx_rdy  = 1'b1;
    lat     = 0;
    do begin
      tick();
      lat++;
    end while (!rx_rdy_clr && lat < 8);
    tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    int rs, gap, wcnt;

    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("reset_count", count, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_clr", rx_rdy_clr, 0);
    chk("reset_irq", irq, 0);

    // Single byte
    rx_data = 8'hA5;
    rx_rdy  = 1'b1;
    tick();
    chk("single_clr", rx_rdy_clr, 1);
    chk("single_valid", rd_valid, 1);
    chk("single_data", rd_data, 8'hA5);
    chk("single_count", count, 1);
    tick();
    chk("single_clr_width", rx_rdy_clr, 0);
    rx_rdy = 1'b0;
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("single_pop_count", count, 0);
    chk("single_pop_valid", rd_valid, 0);

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), lat);
      chk("fill_clr_latency", lat, 1);
`ifdef UART_RX_FIFO_THRESH_EN
      if (i == 6 || i == 7) chk("fill_irq", irq, (i >= 7) ? 1 : 0);
`else
      if (i == 7) chk("fill_irq_off", irq, 0);
`endif
    end
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 0);
    chk("fill_head", rd_data, 8'h00);

    // Overflow
    send_byte(8'hEE, lat);
    chk("ovf_clr_pulse", lat, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_head", rd_data, 8'h00);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Drop coincident with ovf_clr: set wins
    rx_data = 8'hEF;
    rx_rdy  = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    tick();
    rx_rdy = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Full: pop and push in the same cycle
    rx_data  = 8'h5A;
    rx_rdy   = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("fullpp_count", count, 16);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", rd_data, 8'h01);
    tick();
    rx_rdy = 1'b0;
    tick();

    // Drain, one per cycle, in order
    rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      tick();
    end
    chk("drain_last", rd_data, 8'h5A);
    tick();
    rd_ready = 1'b0;
    chk("drain_empty", rd_valid, 0);
    chk("drain_count", count, 0);

    // Reset while capture FSM is in CLR with count=5
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), lat);
    chk("mid_count5", count, 5);
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    tick();
    chk("mid_in_clr", rx_rdy_clr, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_clr", rx_rdy_clr, 0);
    rst = 1'b1;
    tick();
    chk("mid_recapture", count, 1);
    chk("mid_recapture_data", rd_data, 8'h77);
    chk("mid_recapture_clr", rx_rdy_clr, 1);
    repeat (3) tick();
    chk("mid_single_capture", count, 1);
    rx_rdy = 1'b0;
    repeat (2) tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // Randomized traffic, including occasional back-to-back re-assertion
    rs  = 0;
    gap = 2;
    wcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rd_ready = ($urandom_range(0, 99) < ((c < 1500) ? 20 : 70));
      ovf_clr  = ($urandom_range(0, 19) == 0);
      case (rs)
        0: begin
          if (gap > 0) gap--;
          else begin
            rx_data = 8'($urandom);
            rx_rdy  = 1'b1;
            wcnt    = 0;
            rs      = 1;
          end
        end
        1: begin
          if (rx_rdy_clr) begin
            if ($urandom_range(0, 15) == 0) begin
              rx_data = 8'($urandom);
              wcnt    = 0;
            end else begin
              rs = 2;
            end
          end else begin
            wcnt++;
            if (wcnt > 20) begin
              rx_rdy = 1'b0;
              gap    = $urandom_range(1, 6);
              rs     = 0;
            end
          end
        end
        default: begin
          rx_rdy = 1'b0;
          gap    = $urandom_range(1, 6);
          rs     = 0;
        end
      endcase
      tick();
    end

    rx_rdy   = 1'b0;
    ovf_clr  = 1'b0;
    rd_ready = 1'b1;
    repeat (40) tick();
    chk("final_empty", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
